// File: rtl/nn_argmax_classifier.sv
// -----------------------------------------------------------------------------
// nn_argmax_classifier
//
// Purpose:
//    Downstream stage of the network top. On the rising edge of the network
//    completion flag it snapshots the N signed network outputs. It then walks
//    the snapshot one element per cycle and keeps a running maximum (with its
//    index) and runner-up. It presents index, maximum, runner-up and margin
//    through a valid/ready handshake.
//
// Ports:
//    clk         system clock, all state changes on posedge
//    rst         synchronous active-high reset
//    net_ack     network completion flag (level; only its rising edge counts)
//    net_vec     N packed signed W-bit outputs, element k at [k*W +: W]
//    busy        high while a captured vector is being scanned
//    res_valid   result available (held until res_ready)
//    res_ready   consumer accepts the result
//    res_index   index of the maximum element (lowest index on ties)
//    res_max     signed maximum value
//    res_second  signed runner-up value
//    res_margin  signed res_max - res_second in W+1 bits, never negative
//    overrun     sticky: a rising edge of net_ack arrived while not idle
// -----------------------------------------------------------------------------
module nn_argmax_classifier #(
   parameter int N  = 8,
   parameter int W  = 8,
   parameter int IW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              net_ack,
   input  logic [N*W-1:0]    net_vec,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IW-1:0]     res_index,
   output logic [W-1:0]      res_max,
   output logic [W-1:0]      res_second,
   output logic [W:0]        res_margin,
   output logic              overrun
);

   // Pointer must be able to hold N itself: the value N marks the cycle in
   // which the last comparison has settled and the result is registered.
   localparam int PW = $clog2(N + 1);
   localparam logic [PW-1:0] PTR_END = PW'(N);
   localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic                 ack_prev_q, ack_prev_d;
   logic                 overrun_q, overrun_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic signed [W-1:0]  best_q, best_d;
   logic signed [W-1:0]  second_q, second_d;
   logic [IW-1:0]        idx_q, idx_d;

   logic [IW-1:0]        res_index_q, res_index_d;
   logic [W-1:0]         res_max_q, res_max_d;
   logic [W-1:0]         res_second_q, res_second_d;
   logic [W:0]           res_margin_q, res_margin_d;

   logic signed [W-1:0]  net_elem [N];
   logic signed [W-1:0]  elem_q [N];
   logic signed [W-1:0]  elem_d [N];

   logic                 start;
   logic [IW-1:0]        ptr_idx;
   logic signed [W-1:0]  scan_e;
   logic [W:0]           margin_calc;

   // Unpack the flat input bus into an array of signed elements.
   for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign net_elem[gi] = net_vec[gi*W +: W];
   end

   assign start = net_ack & ~ack_prev_q;

   // The pointer reaches N only in the finishing cycle, where the element
   // read is unused; keep the array index in range regardless.
   assign ptr_idx = (ptr_q < PTR_END) ? ptr_q[IW-1:0] : '0;
   assign scan_e  = elem_q[ptr_idx];

   // Sign-extend both operands one bit so the difference cannot overflow.
   assign margin_calc = {best_q[W-1], best_q} - {second_q[W-1], second_q};

   always_comb begin
      state_d      = state_q;
      ack_prev_d   = net_ack;
      overrun_d    = overrun_q;
      ptr_d        = ptr_q;
      best_d       = best_q;
      second_d     = second_q;
      idx_d        = idx_q;
      elem_d       = elem_q;
      res_index_d  = res_index_q;
      res_max_d    = res_max_q;
      res_second_d = res_second_q;
      res_margin_d = res_margin_q;

      // Any new inference arriving while we still own a vector is lost.
      if (start && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               elem_d   = net_elem;
               best_d   = net_elem[0];
               idx_d    = '0;
               second_d = MOST_NEG;
               ptr_d    = PW'(1);
               state_d  = S_SCAN;
            end
         end

         S_SCAN: begin
            if (ptr_q == PTR_END) begin
               res_index_d  = idx_q;
               res_max_d    = best_q;
               res_second_d = second_q;
               res_margin_d = margin_calc;
               state_d      = S_HOLD;
            end else begin
               // Strict compare keeps the lowest index on ties; the tied
               // value then lands in second via the else branch.
               if (scan_e > best_q) begin
                  second_d = best_q;
                  best_d   = scan_e;
                  idx_d    = ptr_q[IW-1:0];
               end else if (scan_e > second_q) begin
                  second_d = scan_e;
               end
               ptr_d = ptr_q + PW'(1);
            end
         end

         S_HOLD: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ack_prev_q   <= 1'b0;
         overrun_q    <= 1'b0;
         ptr_q        <= '0;
         best_q       <= '0;
         second_q     <= '0;
         idx_q        <= '0;
         res_index_q  <= '0;
         res_max_q    <= '0;
         res_second_q <= '0;
         res_margin_q <= '0;
         for (int i = 0; i < N; i++) begin
            elem_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         ack_prev_q   <= ack_prev_d;
         overrun_q    <= overrun_d;
         ptr_q        <= ptr_d;
         best_q       <= best_d;
         second_q     <= second_d;
         idx_q        <= idx_d;
         res_index_q  <= res_index_d;
         res_max_q    <= res_max_d;
         res_second_q <= res_second_d;
         res_margin_q <= res_margin_d;
         elem_q       <= elem_d;
      end
   end

   assign busy       = (state_q == S_SCAN);
   assign res_valid  = (state_q == S_HOLD);
   assign res_index  = res_index_q;
   assign res_max    = res_max_q;
   assign res_second = res_second_q;
   assign res_margin = res_margin_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_nn_argmax_classifier.sv
module tb_nn_argmax_classifier;
   localparam int N  = 8;
   localparam int W  = 8;
   localparam int IW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           net_ack;
   logic [N*W-1:0] net_vec;
   logic           busy;
   logic           res_valid;
   logic           res_ready;
   logic [IW-1:0]  res_index;
   logic [W-1:0]   res_max;
   logic [W-1:0]   res_second;
   logic [W:0]     res_margin;
   logic           overrun;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   nn_argmax_classifier #(.N(N), .W(W), .IW(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .net_ack    (net_ack),
      .net_vec    (net_vec),
      .busy       (busy),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_index  (res_index),
      .res_max    (res_max),
      .res_second (res_second),
      .res_margin (res_margin),
      .overrun    (overrun)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: argmax with lowest index on ties; runner-up is the largest
   // value at any other position.
   function automatic void model(input int v[N], output int idx,
                                 output int mx, output int sec);
      idx = 0;
      mx  = v[0];
      for (int k = 1; k < N; k++) begin
         if (v[k] > mx) begin
            mx  = v[k];
            idx = k;
         end
      end
      sec = -100000;
      for (int k = 0; k < N; k++) begin
         if (k != idx && v[k] > sec) sec = v[k];
      end
   endfunction

   task automatic set_vec(input int v[N]);
      for (int k = 0; k < N; k++) net_vec[k*W +: W] = W'(v[k]);
   endtask

   // Produce one rising edge of net_ack, scramble net_vec mid-scan and check
   // the latency and the result. net_ack is left high.
   task automatic run_vec(input int v[N], input string tag);
      int idx, mx, sec, c;
      model(v, idx, mx, sec);
      net_ack = 1'b0;
      set_vec(v);
      tick();
      net_ack = 1'b1;
      c = 0;
      while (!res_valid && c < 40) begin
         tick();
         c++;
         if (c == 2) net_vec = {$urandom, $urandom};
      end
      check({tag, "_latency"}, c - 1, N);
      check({tag, "_index"}, int'(res_index), idx);
      check({tag, "_max"}, int'($signed(res_max)), mx);
      check({tag, "_second"}, int'($signed(res_second)), sec);
      check({tag, "_margin"}, int'($signed(res_margin)), mx - sec);
   endtask

   task automatic accept_check(input string tag);
      tick();
      check({tag, "_valid_drop"}, int'(res_valid), 0);
      check({tag, "_busy_after"}, int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v[N];
      int idx, mx, sec, cnt, exp_pack;
      logic [7:0] b;

      rst = 1'b1; net_ack = 1'b0; net_vec = '0; res_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(res_valid), 0);
      check("rst_index", int'(res_index), 0);
      check("rst_max", int'(res_max), 0);
      check("rst_second", int'(res_second), 0);
      check("rst_margin", int'(res_margin), 0);
      check("rst_overrun", int'(overrun), 0);

      v = '{5, -3, 17, 2, 0, 9, -128, 1};
      run_vec(v, "basic");
      check("basic_index_const", int'(res_index), 2);
      check("basic_margin_const", int'(res_margin), 8);
      accept_check("basic");

      v = '{-7, -7, -7, -7, -7, -7, -7, -7};
      run_vec(v, "tie_all");
      accept_check("tie_all");

      v = '{-128, -128, -128, -128, -128, -128, -128, -127};
      run_vec(v, "neg_last");
      accept_check("neg_last");

      v = '{-128, -128, -128, 127, -128, -128, -128, -128};
      run_vec(v, "extreme");
      check("extreme_margin_bits", int'(res_margin), 255);
      accept_check("extreme");

      for (int r = 0; r < 12; r++) begin
         for (int k = 0; k < N; k++) begin
            if (r % 2 == 1) begin
               v[k] = int'($urandom_range(0, 6)) - 3;
            end else begin
               b = 8'($urandom);
               v[k] = int'($signed(b));
            end
         end
         run_vec(v, $sformatf("rand%0d", r));
         accept_check($sformatf("rand%0d", r));
      end

      // Backpressure: result frozen while res_ready is low.
      res_ready = 1'b0;
      v = '{3, 44, -9, 44, 12, -100, 0, 43};
      model(v, idx, mx, sec);
      exp_pack = int'({1'b1, IW'(idx), W'(mx), W'(sec), (W+1)'(mx - sec)});
      run_vec(v, "bp");
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_stable",
               int'({res_valid, res_index, res_max, res_second, res_margin}),
               exp_pack);
      end
      check("bp_busy", int'(busy), 0);
      res_ready = 1'b1;
      accept_check("bp");

      // Level-held net_ack: no retrigger.
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (res_valid) cnt++;
      end
      check("level_no_retrigger", cnt, 0);
      check("level_overrun", int'(overrun), 0);

      // Re-raise during HOLD: overrun, no second result.
      res_ready = 1'b0;
      v = '{10, 20, 30, 40, 50, 60, 70, -1};
      run_vec(v, "ovr");
      net_ack = 1'b0;
      tick();
      net_ack = 1'b1;
      tick();
      check("ovr_set", int'(overrun), 1);
      check("ovr_valid_held", int'(res_valid), 1);
      res_ready = 1'b1;
      accept_check("ovr");
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (res_valid || busy) cnt++;
      end
      check("ovr_no_second", cnt, 0);
      check("ovr_sticky", int'(overrun), 1);

      // Reset mid-scan.
      net_ack = 1'b0;
      tick();
      net_ack = 1'b1;
      tick(); tick(); tick(); tick();
      check("mid_busy_before", int'(busy), 1);
      rst = 1'b1;
      tick();
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_valid", int'(res_valid), 0);
      check("mid_rst_overrun", int'(overrun), 0);
      rst = 1'b0;
      net_ack = 1'b0;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (res_valid) cnt++;
      end
      check("mid_no_result", cnt, 0);
      v = '{1, 2, 3, 4, 5, 6, 7, 8};
      run_vec(v, "after_rst");
      accept_check("after_rst");
      net_ack = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
